// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF challenge sequencer.
// Holds the FSM state encoding, LFSR polynomial and synchroniser depth.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD,
        ST_MEASURE,
        ST_SAMPLE,
        ST_DONE
    } puf_state_t;

    // x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask over bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] SEED_ZERO_SUB = 8'hA5;

    localparam int RESP_W_DEF    = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int SAMPLE_CYCLES = SYNC_STAGES + 1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// 8-bit Fibonacci LFSR for challenge generation; a zero seed is substituted
// so the register can never lock up in the all-zero state.
module puf_lfsr8
    import puf_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= '0;
        end else if (load) begin
            lfsr_q <= (seed == 8'h00) ? SEED_ZERO_SUB : seed;
        end else if (step) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/puf_challenge_seq.sv
// Initiator for the RO-PUF: sequences challenges, times the reset/measure
// window and packs synchronised responses into a key. Optional macro
// PUF_MAJORITY_VOTE_EN measures each challenge three times and keeps the majority.
//
// state   | meaning
// IDLE    | PUF held in reset, waiting for start
// CHECK   | reject challenges that select the same RO twice
// LOAD    | new selects applied, PUF held in reset to settle
// MEASURE | ROs and counters running
// SAMPLE  | flush synchroniser, capture response on last cycle
// DONE    | one-cycle completion pulse
module puf_challenge_seq
    import puf_pkg::*;
#(
    parameter int NUM_CHALLENGES = 8,
    parameter int RESP_W         = RESP_W_DEF,
    parameter int SETTLE_CYCLES  = 4,
    parameter int MEASURE_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [7:0]                       seed,
    output logic [3:0]                       sel0,
    output logic [3:0]                       sel1,
    output logic                             puf_reset,
    input  logic [RESP_W-1:0]                puf_response,
    output logic                             busy,
    output logic                             done,
    output logic                             key_valid,
    output logic [NUM_CHALLENGES*RESP_W-1:0] key_out
);

    localparam int KEY_W  = NUM_CHALLENGES * RESP_W;
    localparam int TMAX_A = (MEASURE_CYCLES > SETTLE_CYCLES) ? MEASURE_CYCLES : SETTLE_CYCLES;
    localparam int TMAX   = (TMAX_A > SAMPLE_CYCLES) ? TMAX_A : SAMPLE_CYCLES;
    localparam int TMR_W  = $clog2(TMAX + 1);
    localparam int IDX_W  = (NUM_CHALLENGES > 1) ? $clog2(NUM_CHALLENGES) : 1;

    puf_state_t        state_q, state_d;
    logic [7:0]        lfsr;
    logic              lfsr_load, lfsr_step;
    logic [TMR_W-1:0]  timer_q;
    logic              timer_zero;
    logic [IDX_W-1:0]  idx_q;
    logic              idx_last;
    logic              last_pass;
    logic [3:0]        sel0_q, sel1_q;
    logic              puf_reset_q, busy_q, done_q, key_valid_q;
    logic [KEY_W-1:0]  key_q;
    logic [RESP_W-1:0] sync_q [SYNC_STAGES];
    logic [RESP_W-1:0] synced;
    logic [RESP_W-1:0] sample_val;

    puf_lfsr8 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .seed    (seed),
        .step    (lfsr_step),
        .state   (lfsr)
    );

    assign timer_zero = (timer_q == '0);
    assign idx_last   = (idx_q == IDX_W'(NUM_CHALLENGES - 1));
    assign synced     = sync_q[SYNC_STAGES-1];

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]        pass_q;
    logic [RESP_W-1:0] vote_q [2];

    assign last_pass  = (pass_q == 2'd2);
    assign sample_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & synced) | (vote_q[1] & synced);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass_q    <= '0;
            vote_q[0] <= '0;
            vote_q[1] <= '0;
        end else if (state_q == ST_IDLE && start) begin
            pass_q <= '0;
        end else if (state_q == ST_SAMPLE && timer_zero) begin
            if (last_pass) begin
                pass_q <= '0;
            end else begin
                vote_q[pass_q[0]] <= synced;
                pass_q            <= pass_q + 2'd1;
            end
        end
    end
`else
    assign last_pass  = 1'b1;
    assign sample_val = synced;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (lfsr[3:0] == lfsr[7:4]) lfsr_step = 1'b1;
                else                        state_d   = ST_LOAD;
            end
            ST_LOAD:    if (timer_zero) state_d = ST_MEASURE;
            ST_MEASURE: if (timer_zero) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (timer_zero) begin
                    if (!last_pass) begin
                        state_d = ST_LOAD;
                    end else if (idx_last) begin
                        state_d = ST_DONE;
                    end else begin
                        lfsr_step = 1'b1;
                        state_d   = ST_CHECK;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer reloads on every state change, so each phase length is set here only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            case (state_d)
                ST_LOAD:    timer_q <= TMR_W'(SETTLE_CYCLES - 1);
                ST_MEASURE: timer_q <= TMR_W'(MEASURE_CYCLES - 1);
                ST_SAMPLE:  timer_q <= TMR_W'(SAMPLE_CYCLES - 1);
                default:    timer_q <= '0;
            endcase
        end else if (!timer_zero) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= puf_response;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Control outputs are registered from the next state so the PUF sees clean edges
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            puf_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            puf_reset_q <= !(state_d == ST_MEASURE || state_d == ST_SAMPLE);
            busy_q      <= (state_d == ST_CHECK) || (state_d == ST_LOAD) ||
                           (state_d == ST_MEASURE) || (state_d == ST_SAMPLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            sel0_q      <= '0;
            sel1_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q       <= '0;
                        key_q       <= '0;
                        key_valid_q <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (state_d == ST_LOAD) begin
                        sel0_q <= lfsr[3:0];
                        sel1_q <= lfsr[7:4];
                    end
                end
                ST_SAMPLE: begin
                    if (timer_zero && last_pass) begin
                        for (int k = 0; k < NUM_CHALLENGES; k++) begin
                            if (idx_q == IDX_W'(k)) key_q[k*RESP_W +: RESP_W] <= sample_val;
                        end
                        if (!idx_last) idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: key_valid_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign sel0      = sel0_q;
    assign sel1      = sel1_q;
    assign puf_reset = puf_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_valid = key_valid_q;
    assign key_out   = key_q;

endmodule

// File: tb/tb_puf_challenge_seq.sv
// Directed bench for puf_challenge_seq with a stub PUF returning sel0^sel1
// while puf_reset is low; with PUF_MAJORITY_VOTE_EN one pass in three is corrupted.
module tb_puf_challenge_seq;

    localparam int NCH    = 2;
    localparam int RESP_W = 4;
    localparam int SETTLE = 4;
    localparam int MEAS   = 16;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int PER = 1 + 3 * (SETTLE + MEAS + 3);
`else
    localparam int PER = 1 + SETTLE + MEAS + 3;
`endif

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    start;
    logic [7:0]              seed;
    logic [3:0]              sel0, sel1;
    logic                    puf_reset;
    logic [RESP_W-1:0]       puf_response;
    logic                    busy, done, key_valid;
    logic [NCH*RESP_W-1:0]   key_out;

    int n_cmp = 0;
    int n_bad = 0;
    int meas_cnt = 0;
    int eq_viol = 0;

    puf_challenge_seq #(
        .NUM_CHALLENGES (NCH),
        .RESP_W         (RESP_W),
        .SETTLE_CYCLES  (SETTLE),
        .MEASURE_CYCLES (MEAS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .seed         (seed),
        .sel0         (sel0),
        .sel1         (sel1),
        .puf_reset    (puf_reset),
        .puf_response (puf_response),
        .busy         (busy),
        .done         (done),
        .key_valid    (key_valid),
        .key_out      (key_out)
    );

    always #5 clk = ~clk;

    always @(negedge puf_reset) meas_cnt++;

    always_comb begin
        puf_response = sel0 ^ sel1;
`ifdef PUF_MAJORITY_VOTE_EN
        if (meas_cnt % 3 == 2) puf_response[0] = ~puf_response[0];
`endif
        if (puf_reset) puf_response = '0;
    end

    always @(negedge clk) begin
        if (reset_n && !puf_reset && sel0 == sel1) eq_viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run from start to done; counts busy/done cycles and the first challenge's
    // settle (puf_reset high with the expected selects) and low-window lengths.
    task automatic run(input logic [7:0] sd, input int pulse_at,
                       input logic [3:0] e0, input logic [3:0] e1,
                       output int busy_n, output int done_n,
                       output int hi_n, output int low_n,
                       output logic kv0, output logic [31:0] key0);
        int phase;
        busy_n = 0; done_n = 0; hi_n = 0; low_n = 0; phase = 0;
        kv0 = 1'b1; key0 = '1;
        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kv0   = key_valid;
        key0  = 32'(key_out);
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (busy) busy_n++;
            if (done) done_n++;
            if (phase == 0) begin
                if (!puf_reset) begin
                    phase = 1;
                    low_n = 1;
                end else if (sel0 == e0 && sel1 == e1) begin
                    hi_n++;
                end
            end else if (phase == 1) begin
                if (!puf_reset) low_n++;
                else            phase = 2;
            end
            start = (cyc == pulse_at);
            if (done) break;
            @(negedge clk);
        end
        start = 1'b0;
        if (done_n == 0) check_eq("timeout_done", 32'(done_n), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int bn, dn, hn, ln;
        logic kv;
        logic [31:0] k0;

        reset_n = 1'b0;
        start   = 1'b0;
        seed    = 8'h00;
        #12;
        check_eq("rst_busy",      32'(busy),      32'd0);
        check_eq("rst_done",      32'(done),      32'd0);
        check_eq("rst_key_valid", 32'(key_valid), 32'd0);
        check_eq("rst_key_out",   32'(key_out),   32'd0);
        check_eq("rst_puf_reset", 32'(puf_reset), 32'd1);
        check_eq("rst_sel0",      32'(sel0),      32'd0);
        check_eq("rst_sel1",      32'(sel1),      32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // seed 12: challenges 0x12 -> 3, 0x25 -> 7
        run(8'h12, -1, 4'h2, 4'h1, bn, dn, hn, ln, kv, k0);
        check_eq("s12_key",       32'(key_out),   32'h73);
        check_eq("s12_busy",      32'(bn),        32'(2 * PER));
        check_eq("s12_done",      32'(dn),        32'd1);
        check_eq("s12_settle",    32'(hn),        32'(SETTLE));
        check_eq("s12_low",       32'(ln),        32'(MEAS + 3));
        check_eq("s12_key_valid", 32'(key_valid), 32'd1);

        // seed 0 -> A5 -> F, then 4A -> E; start while key_valid clears the key
        run(8'h00, -1, 4'h5, 4'hA, bn, dn, hn, ln, kv, k0);
        check_eq("s00_kv_cleared",  32'(kv),      32'd0);
        check_eq("s00_key_cleared", k0,           32'd0);
        check_eq("s00_key",       32'(key_out),   32'hEF);
        check_eq("s00_done",      32'(dn),        32'd1);
        check_eq("s00_settle",    32'(hn),        32'(SETTLE));
        repeat (5) @(negedge clk);
        check_eq("s00_kv_hold",   32'(key_valid), 32'd1);
        check_eq("s00_done_low",  32'(done),      32'd0);

        // seed 33 -> 66 -> CD (two skips) -> 1, then 9A -> 3
        run(8'h33, -1, 4'hD, 4'hC, bn, dn, hn, ln, kv, k0);
        check_eq("s33_key",       32'(key_out),   32'h31);
        check_eq("s33_busy",      32'(bn),        32'(2 * PER + 2));
        check_eq("s33_settle",    32'(hn),        32'(SETTLE));
        check_eq("eq_sel_measured", 32'(eq_viol), 32'd0);

        // start pulsed mid-MEASURE is ignored
        run(8'h12, 10, 4'h2, 4'h1, bn, dn, hn, ln, kv, k0);
        check_eq("ign_key",       32'(key_out),   32'h73);
        check_eq("ign_busy",      32'(bn),        32'(2 * PER));
        check_eq("ign_done",      32'(dn),        32'd1);
        repeat (3) @(negedge clk);
        check_eq("ign_idle",      32'(busy),      32'd0);

        // async reset during MEASURE
        @(negedge clk);
        seed  = 8'h12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("mid_puf_low",   32'(puf_reset), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("ar_busy",       32'(busy),      32'd0);
        check_eq("ar_key_valid",  32'(key_valid), 32'd0);
        check_eq("ar_key_out",    32'(key_out),   32'd0);
        check_eq("ar_puf_reset",  32'(puf_reset), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        run(8'h00, -1, 4'h5, 4'hA, bn, dn, hn, ln, kv, k0);
        check_eq("post_rst_key",  32'(key_out),   32'hEF);
        check_eq("post_rst_done", 32'(dn),        32'd1);
        check_eq("post_rst_busy", 32'(bn),        32'(2 * PER));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
